demux_16_bit: RTL and testbench



---
 rtl/demux_16_bit_pkg.sv | 34 +++
 rtl/demux_16_bit_if.sv | 11 +
 rtl/onehot_decode_4to16.sv | 18 +
 rtl/demux_16_bit.sv | 83 ++++++++
 tb/tb_demux_16_bit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_16_bit_pkg.sv
// Shared widths, code names and FSM states for the 4-to-16 enable decoder.
package demux_16_bit_pkg;

    localparam int CODE_W = 4;
    localparam int OUT_W  = 16;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [OUT_W-1:0]  onehot_t;

    // Analog block selected by each enable code; code 0 powers everything off.
    localparam code_t CODE_OFF               = 4'd0;
    localparam code_t CODE_OTA_LASCAS        = 4'd1;
    localparam code_t CODE_OTA_D2S_ENH       = 4'd2;
    localparam code_t CODE_OTA_TREE          = 4'd3;
    localparam code_t CODE_OTA_DIG_REZA      = 4'd4;
    localparam code_t CODE_OTA_GAIN_BOOSTING = 4'd5;
    localparam code_t CODE_COMP_JLPEA        = 4'd6;
    localparam code_t CODE_COMP_ACCESS       = 4'd7;
    localparam code_t CODE_LDO               = 4'd8;
    localparam code_t CODE_LDO_1NA           = 4'd9;
    localparam code_t CODE_LDO_10NA          = 4'd10;
    localparam code_t CODE_LDO_100NA         = 4'd11;
    localparam code_t CODE_LDO_250NA         = 4'd12;
    localparam code_t CODE_LDO_500NA         = 4'd13;
    localparam code_t CODE_LDO_750NA         = 4'd14;
    localparam code_t CODE_LDO_1UA           = 4'd15;

    // ST_RUN: a code (possibly off) is applied; ST_GAP: break-before-make in progress.
    typedef enum logic {
        ST_RUN = 1'b0,
        ST_GAP = 1'b1
    } state_t;

endpackage

// File: rtl/demux_16_bit_if.sv
// Enable-controller bus: requested code in, enable lines and gap flag out.
interface demux_16_bit_if;

    demux_16_bit_pkg::code_t   sel;
    demux_16_bit_pkg::onehot_t out;
    logic                      busy;

    modport master (output sel, input out, input busy);
    modport slave  (input sel, output out, output busy);

endinterface

// File: rtl/onehot_decode_4to16.sv
// Combinational code to one-hot decode; code 0 maps to all-zero so bit 0 never rises.
module onehot_decode_4to16
    import demux_16_bit_pkg::*;
(
    input  code_t   code,
    output onehot_t onehot
);

    // Set the single bit selected by a non-zero code.
    always_comb begin
        // NOTE: default assigned first so every path drives onehot; no latch.
        onehot = '0;
        if (code != CODE_OFF) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_16_bit.sv
// Registered 4-to-16 enable decoder with a break-before-make gap between two
// different non-zero codes, so two analog blocks are never enabled together.
module demux_16_bit
    import demux_16_bit_pkg::*;
#(
    parameter int unsigned BBM_CYCLES = 1   // all-off cycles between non-zero codes, 0..15
) (
    input  logic           clk,
    input  logic           rst,
    demux_16_bit_if.slave  bus
);

    localparam logic [3:0] GAP_INIT = 4'(BBM_CYCLES);

    state_t     state_q, state_d;
    code_t      applied_q, applied_d;   // code currently driving out (0 during a gap)
    logic [3:0] cnt_q, cnt_d;           // gap cycles still to run
    onehot_t    out_q, out_d;
    onehot_t    sel_onehot;

    onehot_decode_4to16 u_decode (
        .code   (bus.sel),
        .onehot (sel_onehot)
    );

    // Next-state logic: apply, hold, or route a non-zero change through an all-off gap.
    // The gap does not keep its own target: whatever sel is sampled on the final
    // gap edge is what gets applied, which makes the newest request win.
    always_comb begin
        state_d   = state_q;
        applied_d = applied_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.sel != applied_q) begin
                    if (bus.sel == CODE_OFF || applied_q == CODE_OFF || BBM_CYCLES == 0) begin
                        out_d     = sel_onehot;
                        applied_d = bus.sel;
                    end else begin
                        out_d     = '0;
                        applied_d = CODE_OFF;
                        cnt_d     = GAP_INIT;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                out_d = '0;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d   = ST_RUN;
                    out_d     = sel_onehot;
                    applied_d = bus.sel;
                end
            end
            default: begin
                state_d = ST_RUN;
                out_d   = '0;
            end
        endcase
    end

    // State and output registers; reset forces every enable off immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            applied_q <= CODE_OFF;
            cnt_q     <= '0;
            out_q     <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            state_q   <= state_d;
            applied_q <= applied_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = (state_q == ST_GAP);

endmodule

// File: tb/tb_demux_16_bit.sv
// Bench for demux_16_bit: three instances (BBM_CYCLES = 0, 1, 3) share one sel
// and are each compared every cycle against a behavioural model, plus directed
// scenario checks written as literal expected values.
module tb_demux_16_bit;
    import demux_16_bit_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    code_t sel;

    always #5 clk = ~clk;

    demux_16_bit_if if0 ();
    demux_16_bit_if if1 ();
    demux_16_bit_if if3 ();

    assign if0.sel = sel;
    assign if1.sel = sel;
    assign if3.sel = sel;

    demux_16_bit #(.BBM_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    demux_16_bit #(.BBM_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    demux_16_bit #(.BBM_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    int vectors     = 0;
    int miscompares = 0;

    // Model: which code is live, and how many all-off cycles remain.
    int          m_cur  [3];
    int          m_left [3];
    logic [15:0] prev_out [3];

    function automatic int bbm_of(int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [15:0] obs_out(int i);
        case (i)
            0:       return if0.out;
            1:       return if1.out;
            default: return if3.out;
        endcase
    endfunction

    function automatic logic obs_busy(int i);
        case (i)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if3.busy;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cur[i]    = 0;
            m_left[i]   = 0;
            prev_out[i] = 16'h0000;
        end
    endtask

    // One clock: advance the model with the sel seen at the edge, then compare.
    task automatic tick();
        logic [15:0] exp_out;
        logic        exp_busy;
        logic [15:0] got;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) m_cur[i] = int'(sel);
            end else if (int'(sel) != m_cur[i]) begin
                if (sel == 0 || m_cur[i] == 0 || bbm_of(i) == 0) begin
                    m_cur[i] = int'(sel);
                end else begin
                    m_cur[i]  = 0;
                    m_left[i] = bbm_of(i);
                end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_out  = (m_cur[i] == 0) ? 16'h0000 : (16'h0001 << m_cur[i]);
            exp_busy = (m_left[i] > 0);
            got      = obs_out(i);
            vectors++;
            if (got !== exp_out || obs_busy(i) !== exp_busy) begin
                miscompares++;
                $display("FAIL model[bbm=%0d] t=%0t: out=%h busy=%b, want out=%h busy=%b",
                         bbm_of(i), $time, got, obs_busy(i), exp_out, exp_busy);
            end
            vectors++;
            if ($countones(got) > 1 || got[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL onehot0[bbm=%0d] t=%0t: out=%h, want onehot0 with bit0=0",
                         bbm_of(i), $time, got);
            end
            if (bbm_of(i) > 0) begin
                vectors++;
                if (prev_out[i] != 16'h0000 && got != 16'h0000 && got != prev_out[i]) begin
                    miscompares++;
                    $display("FAIL bbm_gap[bbm=%0d] t=%0t: out %h -> %h, want all-off between",
                             bbm_of(i), $time, prev_out[i], got);
                end
            end
            prev_out[i] = got;
        end
    endtask

    task automatic settle(int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel = CODE_OFF;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_out(i) !== 16'h0000 || obs_busy(i) !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[bbm=%0d]: out=%h busy=%b, want 0000/0",
                         bbm_of(i), obs_out(i), obs_busy(i));
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [15:0] want;
        for (int c = 0; c < 16; c++) begin
            sel = 4'(c);
            tick();
            want = (c == 0) ? 16'h0000 : (16'h0001 << c);
            vectors++;
            if (if0.out !== want) begin
                miscompares++;
                $display("FAIL sweep code=%0d: out=%h, want %h", c, if0.out, want);
            end
            settle(9);
        end
    endtask

    task automatic test_bbm1();
        sel = CODE_OTA_LASCAS;
        settle(5);
        sel = CODE_OTA_D2S_ENH;
        tick();
        vectors++;
        if (if1.out !== 16'h0000 || if1.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bbm1_gap: out=%h busy=%b, want 0000/1", if1.out, if1.busy);
        end
        tick();
        vectors++;
        if (if1.out !== 16'h0004 || if1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bbm1_apply: out=%h busy=%b, want 0004/0", if1.out, if1.busy);
        end
    endtask

    task automatic test_zero_transitions();
        sel = CODE_LDO;
        settle(5);
        repeat (2) begin
            sel = CODE_OFF;
            tick();
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs_out(i) !== 16'h0000 || obs_busy(i) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL to_zero[bbm=%0d]: out=%h busy=%b, want 0000/0",
                             bbm_of(i), obs_out(i), obs_busy(i));
                end
            end
            sel = CODE_LDO;
            tick();
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs_out(i) !== 16'h0100 || obs_busy(i) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL from_zero[bbm=%0d]: out=%h busy=%b, want 0100/0",
                             bbm_of(i), obs_out(i), obs_busy(i));
                end
            end
        end
    endtask

    task automatic test_bbm3_retarget();
        sel = CODE_OTA_TREE;
        settle(6);
        sel = CODE_OTA_GAIN_BOOSTING;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) sel = CODE_COMP_ACCESS;
            vectors++;
            if (if3.out !== 16'h0000 || if3.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bbm3_gap cycle=%0d: out=%h busy=%b, want 0000/1",
                         k, if3.out, if3.busy);
            end
        end
        tick();
        vectors++;
        if (if3.out !== 16'h0080 || if3.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bbm3_apply: out=%h busy=%b, want 0080/0", if3.out, if3.busy);
        end
    endtask

    task automatic test_async_reset();
        sel = CODE_LDO_1UA;
        settle(6);
        vectors++;
        if (if0.out !== 16'h8000) begin
            miscompares++;
            $display("FAIL pre_reset: out=%h, want 8000", if0.out);
        end
        // Leave the BBM=3 instance mid-gap when reset hits.
        sel = CODE_LDO_750NA;
        tick();
        sel = CODE_LDO_1UA;
        tick();
        vectors++;
        if (if0.out !== 16'h8000 || if3.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_gap: out0=%h busy3=%b, want 8000/1", if0.out, if3.busy);
        end
        rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_out(i) !== 16'h0000 || obs_busy(i) !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset[bbm=%0d]: out=%h busy=%b, want 0000/0",
                         bbm_of(i), obs_out(i), obs_busy(i));
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_out(i) !== 16'h8000 || obs_busy(i) !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset[bbm=%0d]: out=%h busy=%b, want 8000/0",
                         bbm_of(i), obs_out(i), obs_busy(i));
            end
        end
    endtask

    task automatic test_random();
        repeat (10000) begin
            if ($urandom_range(0, 1) == 0) sel = 4'($urandom_range(0, 15));
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_bbm1();
        test_zero_transitions();
        test_bbm3_retarget();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
